// File: rtl/exp_pipe.sv
// exp_pipe: multi-lane fixed-point exponent, approximately exp(q/256)*256 with 8 fractional bits.
// The input is range-reduced to z*ln2 + p. A quadratic in (p + 346) approximates 2^(p/177).
// The result is then shifted by z. Four stages share one valid/ready handshake and one stall.
`timescale 1ns/1ps

module exp_lane #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          adv,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] res,
  output logic          sat
);
  localparam logic signed [DW-1:0] K177 = DW'(177);
  localparam logic signed [DW-1:0] ONE  = DW'(1);
  localparam logic [DW+8:0]        MAXW = {10'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        MAXR = {1'b0, {(DW-1){1'b1}}};

  // S1 reduce
  logic signed [DW-1:0] qs, quo, rem, z_c;
  logic signed [8:0]    p_c;
  // z is carried at full data width so the most negative input cannot wrap
  logic signed [DW-1:0] z1, z2, z3;
  logic signed [8:0]    p1;
  // S2 square
  logic signed [10:0]   t_c;
  logic [17:0]          t2_c, t2;
  // S3 polynomial
  logic [24:0]          m_c;
  logic [8:0]           l_c, l3;
  // S4 shift/saturate
  logic [DW-1:0]        nz, res_c;
  logic [DW+8:0]        wide;
  logic                 sat_c;

  // Reduction: division truncates toward zero, so positive inputs with a remainder round up to reach ceil
  always_comb begin
    qs  = $signed(q);
    quo = qs / K177;
    rem = qs % K177;
    z_c = (!qs[DW-1] && (qs != '0) && (rem != '0)) ? quo + ONE : quo;
    p_c = 9'(qs - K177 * z_c);
  end

  // Square and polynomial datapath: t is in 170..346, so t*t fits in 18 bits and 92*t2 fits in 25 bits
  always_comb begin
    t_c  = 11'(p1) + 11'sd346;
    t2_c = 18'(t_c[9:0]) * 18'(t_c[9:0]);
    m_c  = 25'(t2) * 25'd92;
    l_c  = m_c[24:16] + 9'd88;
  end

  // Final scaling: right shift for negative z (underflows to 0), saturating left shift otherwise
  always_comb begin
    nz    = -z3;
    wide  = '0;
    res_c = '0;
    sat_c = 1'b0;
    if (z3[DW-1]) begin
      if (nz < DW'(16)) res_c = DW'(l3 >> nz[3:0]);
    end else if (z3 > $signed(DW'(DW - 1))) begin
      res_c = MAXR;
      sat_c = 1'b1;
    end else begin
      wide = (DW+9)'(l3) << z3[4:0];
      if (wide > MAXW) begin
        res_c = MAXR;
        sat_c = 1'b1;
      end else begin
        res_c = wide[DW-1:0];
      end
    end
  end

  // Stage registers: the whole lane advances together, or every stage holds on a stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      z1  <= '0;
      p1  <= '0;
      z2  <= '0;
      t2  <= '0;
      z3  <= '0;
      l3  <= '0;
      res <= '0;
      sat <= 1'b0;
    end else if (adv) begin
      z1  <= z_c;
      p1  <= p_c;
      z2  <= z1;
      t2  <= t2_c;
      z3  <= z2;
      l3  <= l_c;
      res <= res_c;
      sat <= sat_c;
    end
  end
endmodule

module exp_pipe #(
  parameter int DW    = 32,
  parameter int LANES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] in_q,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] out_q,
  output logic [LANES-1:0]    out_sat,
  output logic [2:0]          occupancy
);
  localparam int STAGES = 4;

  logic [STAGES:1]             vld_pipe;
  logic                        in_xfer, stall, adv;
  logic [LANES-1:0][DW-1:0]    q_lane, res_lane;

  assign q_lane    = in_q;
  assign out_q     = res_lane;
  assign out_valid = vld_pipe[STAGES];
  assign stall     = out_valid & ~out_ready;
  assign adv       = ~stall;
  assign in_ready  = adv;
  assign in_xfer   = in_valid & in_ready;

  // Valid shift register: a bubble enters S1 whenever no transfer happens
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     vld_pipe <= '0;
    else if (adv) vld_pipe <= {vld_pipe[STAGES-1:1], in_xfer};
  end

  // Occupancy is the population count of the stage valid bits
  always_comb begin
    occupancy = '0;
    for (int i = 1; i <= STAGES; i++) occupancy = occupancy + 3'(vld_pipe[i]);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    exp_lane #(.DW(DW)) u_lane (
      .clk (clk),
      .rst (rst),
      .adv (adv),
      .q   (q_lane[g]),
      .res (res_lane[g]),
      .sat (out_sat[g])
    );
  end
endmodule

// File: tb/tb_exp_pipe.sv
// Testbench for exp_pipe: directed vectors, a reference model with an expected-result queue, and literal checks.
`timescale 1ns/1ps

module tb_exp_pipe;
  localparam int DW = 32;
  localparam int LANES = 4;
  localparam int VW = DW * LANES;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b1;
  logic [VW-1:0]  in_q = '0;
  logic           in_ready, out_valid;
  logic [VW-1:0]  out_q;
  logic [LANES-1:0] out_sat;
  logic [2:0]     occupancy;

  exp_pipe #(.DW(DW), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_q(out_q), .out_sat(out_sat),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [VW-1:0]    q;
    logic [LANES-1:0] sat;
  } exp_t;
  exp_t exp_fifo[$];

  function automatic void check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endfunction

  // Mathematical definition of one lane, in wide integers
  function automatic void model(input logic [DW-1:0] qin, output logic [DW-1:0] v, output logic s);
    longint qq, z, p, t, l, r;
    qq = longint'($signed(qin));
    if (qq >= 0) z = (qq + 176) / 177;
    else         z = -((-qq) / 177);
    p = qq - 177 * z;
    t = p + 346;
    l = ((92 * t * t) >>> 16) + 88;
    s = 1'b0;
    v = '0;
    if (z < 0) begin
      if (-z < 16) v = DW'(l >>> (-z));
    end else if (z >= 40) begin
      v = 32'h7fffffff; s = 1'b1;
    end else begin
      r = l <<< z;
      if (r > 64'sh7fffffff) begin v = 32'h7fffffff; s = 1'b1; end
      else v = DW'(r);
    end
  endfunction

  function automatic exp_t model_vec(input logic [VW-1:0] q);
    exp_t e;
    logic [DW-1:0] v;
    logic s;
    for (int i = 0; i < LANES; i++) begin
      model(q[i*DW +: DW], v, s);
      e.q[i*DW +: DW] = v;
      e.sat[i] = s;
    end
    return e;
  endfunction

  // Monitor: on every falling edge, compare against the expected queue, the handshake and the hold rules
  logic           have_prev = 1'b0;
  logic [VW-1:0]  prev_q;
  logic [LANES-1:0] prev_sat;
  exp_t           mon_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("rst out_valid", VW'(out_valid), '0);
      check("rst occupancy", VW'(occupancy), '0);
      check("rst out_q", out_q, '0);
      check("rst out_sat", VW'(out_sat), '0);
      exp_fifo.delete();
      have_prev = 1'b0;
    end else begin
      check("occupancy vs model", VW'(occupancy), VW'(exp_fifo.size()));
      check("in_ready", VW'(in_ready), VW'(!(out_valid && !out_ready)));
      if (have_prev && out_valid) begin
        check("stall hold out_q", out_q, prev_q);
        check("stall hold out_sat", VW'(out_sat), VW'(prev_sat));
      end
      if (out_valid && exp_fifo.size() == 0) check("spurious out_valid", VW'(out_valid), '0);
      if (out_valid && out_ready && exp_fifo.size() != 0) begin
        mon_e = exp_fifo.pop_front();
        check("out_q vs model", out_q, mon_e.q);
        check("out_sat vs model", VW'(out_sat), VW'(mon_e.sat));
      end
      have_prev = out_valid && !out_ready;
      prev_q = out_q;
      prev_sat = out_sat;
      if (in_valid && in_ready) exp_fifo.push_back(model_vec(in_q));
    end
  end

  // Holds a vector on the input until it is accepted, then returns #1 after the accepting edge
  task automatic send(input logic [VW-1:0] v);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_q = v;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) check("send timeout", VW'(n), VW'(0));
    in_valid = 1'b0;
  endtask

  task automatic single(input logic [DW-1:0] q, input logic [DW-1:0] expv, input string name);
    int n;
    send({{(VW-DW){1'b0}}, q});
    n = 1;
    while (!out_valid && n < 12) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, " latency"}, VW'(n), VW'(4));
    check({name, " value"}, VW'(out_q[DW-1:0]), VW'(expv));
    check({name, " sat"}, VW'(out_sat[0]), '0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] svec(input int k);
    return {DW'(k * 1000 - 5000), DW'(k * 37), DW'(-k * 177), DW'(k * 50 - 300)};
  endfunction

  initial begin
    logic [DW-1:0] mv;
    logic ms;
    logic [16:0] vpat;
    int peak;

    // The reference model is checked against hand-computed values
    model(32'd0, mv, ms);          check("model q=0", VW'(mv), VW'(256));
    model(-32'sd100, mv, ms);      check("model q=-100", VW'(mv), VW'(172));
    model(32'd1, mv, ms);          check("model q=1", VW'(mv), VW'(256));
    model(32'h7fffffff, mv, ms);   check("model max sat", VW'(ms), VW'(1));

    repeat (3) @(posedge clk);
    #1;
    check("reset occupancy", VW'(occupancy), '0);
    check("reset out_valid", VW'(out_valid), '0);
    rst = 1'b1;
    @(negedge clk);
    check("in_ready after reset", VW'(in_ready), VW'(1));
    @(posedge clk);
    #1;

    // Single lane-0 values
    single(32'd0,    32'd256, "q=0");
    single(-32'sd1,   32'd255, "q=-1");
    single(-32'sd100, 32'd172, "q=-100");
    single(-32'sd177, 32'd128, "q=-177");
    single(32'd177,  32'd512, "q=177");
    single(32'd1,    32'd256, "q=1");

    // Extremes of the input range
    send({64'd0, 32'h80000000, 32'h7fffffff});
    repeat (3) @(posedge clk);
    #1;
    check("max q out", VW'(out_q[31:0]), VW'(32'h7fffffff));
    check("max q sat", VW'(out_sat[0]), VW'(1));
    check("min q out", VW'(out_q[63:32]), '0);
    check("min q sat", VW'(out_sat[1]), '0);
    @(posedge clk);
    #1;

    // Four lanes in one beat
    send({32'hFFFFFE9E, 32'd177, 32'hFFFFFF4F, 32'd0});
    repeat (3) @(posedge clk);
    #1;
    check("4-lane beat", out_q, {32'd64, 32'd512, 32'd128, 32'd256});
    @(posedge clk);
    #1;

    // Back-to-back stream of 10 vectors
    vpat = '0;
    peak = 0;
    in_valid = 1'b1;
    in_q = svec(0);
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      #1;
      vpat[k] = out_valid;
      if (int'(occupancy) > peak) peak = int'(occupancy);
      if (k < 10) in_q = svec(k);
      else in_valid = 1'b0;
    end
    check("stream valid pattern", VW'(vpat), VW'(17'h3FF0));
    check("stream peak occupancy", VW'(peak), VW'(4));

    // Fill and stall, then release with a simultaneous handoff and accept
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(svec(k + 20));
    in_valid = 1'b1;
    in_q = svec(30);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("stall in_ready", VW'(in_ready), '0);
      check("stall occupancy", VW'(occupancy), VW'(4));
      check("stall out_valid", VW'(out_valid), VW'(1));
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(svec(30));
    repeat (6) @(posedge clk);
    #1;
    check("drained occupancy", VW'(occupancy), '0);
    check("drained model queue", VW'(exp_fifo.size()), '0);

    // Reset with three vectors in flight
    send(svec(40));
    send(svec(41));
    send(svec(42));
    check("inflight occupancy", VW'(occupancy), VW'(3));
    rst = 1'b0;
    #1;
    check("async rst out_valid", VW'(out_valid), '0);
    check("async rst occupancy", VW'(occupancy), '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("in_ready after mid reset", VW'(in_ready), VW'(1));
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no output after reset", VW'(out_valid), '0);
    end
    @(posedge clk);
    #1;
    single(-32'sd354, 32'd64, "post-reset q=-354");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
